// File: rtl/fft_bfly_r2_pipe.sv
// fft_bfly_r2_pipe: streaming radix-2 butterfly, one complex pair per beat.
//   y0 = x0 + x1*tw, y1 = x0 - x1*tw, optional conjugate twiddle (inv) and
//   halving (scale), N-bit saturation with sticky ovf, valid/ready flow
//   control and per-frame out_last marking.
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        input handshake (in_ready is combinational)
//   x0_*, x1_*, tw_*, inv, scale   beat payload, sampled on input handshake
//   out_valid/out_ready      output handshake
//   y0_*, y1_*, out_last     results; out_last flags the PAIRS-th output
//   ovf, ovf_clr             sticky saturation flag and its clear
module fft_bfly_r2_pipe #(
    parameter int N     = 16,
    parameter int Q     = 8,
    parameter int PAIRS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [N-1:0] x0_r,
    input  logic signed [N-1:0] x0_i,
    input  logic signed [N-1:0] x1_r,
    input  logic signed [N-1:0] x1_i,
    input  logic signed [N-1:0] tw_r,
    input  logic signed [N-1:0] tw_i,
    input  logic                inv,
    input  logic                scale,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] y0_r,
    output logic signed [N-1:0] y0_i,
    output logic signed [N-1:0] y1_r,
    output logic signed [N-1:0] y1_i,
    output logic                out_last,
    output logic                ovf,
    input  logic                ovf_clr
);
    localparam int STAGES = 3;
    localparam int CW     = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [CW-1:0]          LAST_CNT = CW'(PAIRS - 1);
    localparam logic signed [N-1:0]    WMAX = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0]    WMIN = {1'b1, {(N-1){1'b0}}};
    localparam logic signed [N+2:0]    SMAX = {4'b0000, {(N-1){1'b1}}};
    localparam logic signed [N+2:0]    SMIN = {4'b1111, {(N-1){1'b0}}};
    localparam logic signed [N+2:0]    ONE3 = (N+3)'(1);
    localparam logic signed [2*N:0]    RND  = (2*N+1)'(1) << (Q - 1);

    // Full-precision N x N signed product.
    function automatic logic signed [2*N-1:0] smul(input logic signed [N-1:0] a,
                                                   input logic signed [N-1:0] b);
        logic signed [2*N-1:0] ae, be;
        ae = {{N{a[N-1]}}, a};
        be = {{N{b[N-1]}}, b};
        return ae * be;
    endfunction

    // (a -/+ b + half LSB) >>> Q; the result is kept at N+2 bits, which holds
    // any |x1*tw| with |tw| <= 1.0.
    function automatic logic signed [N+1:0] rnd(input logic signed [2*N-1:0] a,
                                                input logic signed [2*N-1:0] b,
                                                input logic sub);
        logic signed [2*N:0] ae, be, acc;
        ae  = {a[2*N-1], a};
        be  = {b[2*N-1], b};
        acc = sub ? (ae - be) : (ae + be);
        acc = acc + RND;
        acc = acc >>> Q;
        return acc[N+1:0];
    endfunction

    // Optional round-half-up halving, then clip to N bits. Returns {clip, y}.
    function automatic logic [N:0] finish(input logic signed [N+2:0] s,
                                          input logic sc);
        logic signed [N+2:0] v;
        v = s;
        if (sc) begin
            v = v + ONE3;
            v = v >>> 1;
        end
        if (v > SMAX)      return {1'b1, WMAX};
        else if (v < SMIN) return {1'b1, WMIN};
        return {1'b0, v[N-1:0]};
    endfunction

    logic              adv;
    logic [STAGES:1]   vld_pipe;
    logic [CW-1:0]     cnt;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES];
    assign out_last  = out_valid && (cnt == LAST_CNT);

    // Stage 1 input: conjugate twiddle; -(-2^(N-1)) pins to max positive.
    logic signed [N-1:0] tw_i_eff;
    always_comb begin
        tw_i_eff = tw_i;
        if (inv) tw_i_eff = (tw_i == WMIN) ? WMAX : -tw_i;
    end

    logic signed [N-1:0] st1_x0_r, st1_x0_i, st1_x1_r, st1_x1_i, st1_tw_r, st1_tw_i;
    logic                st1_scale;
    logic signed [N-1:0] st2_x0_r, st2_x0_i;
    logic signed [N+1:0] st2_t_r, st2_t_i;
    logic                st2_scale;

    logic signed [2*N-1:0] p_rr, p_ii, p_ri, p_ir;
    assign p_rr = smul(st1_x1_r, st1_tw_r);
    assign p_ii = smul(st1_x1_i, st1_tw_i);
    assign p_ri = smul(st1_x1_r, st1_tw_i);
    assign p_ir = smul(st1_x1_i, st1_tw_r);

    logic signed [N+2:0] a0_r, a0_i, a1_r, a1_i;
    logic [N:0]          r0_r, r0_i, r1_r, r1_i;
    logic                clip_any, ovf_set;

    always_comb begin
        a0_r = {{3{st2_x0_r[N-1]}}, st2_x0_r} + {st2_t_r[N+1], st2_t_r};
        a0_i = {{3{st2_x0_i[N-1]}}, st2_x0_i} + {st2_t_i[N+1], st2_t_i};
        a1_r = {{3{st2_x0_r[N-1]}}, st2_x0_r} - {st2_t_r[N+1], st2_t_r};
        a1_i = {{3{st2_x0_i[N-1]}}, st2_x0_i} - {st2_t_i[N+1], st2_t_i};
        r0_r = finish(a0_r, st2_scale);
        r0_i = finish(a0_i, st2_scale);
        r1_r = finish(a1_r, st2_scale);
        r1_i = finish(a1_i, st2_scale);
    end

    assign clip_any = r0_r[N] | r0_i[N] | r1_r[N] | r1_i[N];
    // Only a beat actually entering the output register may flag overflow.
    assign ovf_set  = adv && vld_pipe[2] && clip_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            st1_x0_r  <= '0; st1_x0_i <= '0; st1_x1_r <= '0; st1_x1_i <= '0;
            st1_tw_r  <= '0; st1_tw_i <= '0; st1_scale <= 1'b0;
            st2_x0_r  <= '0; st2_x0_i <= '0; st2_t_r  <= '0; st2_t_i  <= '0;
            st2_scale <= 1'b0;
            y0_r <= '0; y0_i <= '0; y1_r <= '0; y1_i <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            if (in_valid) begin
                st1_x0_r  <= x0_r;  st1_x0_i <= x0_i;
                st1_x1_r  <= x1_r;  st1_x1_i <= x1_i;
                st1_tw_r  <= tw_r;  st1_tw_i <= tw_i_eff;
                st1_scale <= scale;
            end
            if (vld_pipe[1]) begin
                st2_x0_r  <= st1_x0_r;
                st2_x0_i  <= st1_x0_i;
                st2_t_r   <= rnd(p_rr, p_ii, 1'b1);
                st2_t_i   <= rnd(p_ri, p_ir, 1'b0);
                st2_scale <= st1_scale;
            end
            if (vld_pipe[2]) begin
                y0_r <= r0_r[N-1:0];
                y0_i <= r0_i[N-1:0];
                y1_r <= r1_r[N-1:0];
                y1_i <= r1_i[N-1:0];
            end
        end
    end

    // A fresh saturation outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst)          ovf <= 1'b0;
        else if (ovf_set) ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (out_valid && out_ready)
            cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
    end

endmodule

// File: tb/tb_fft_bfly_r2_pipe.sv
module tb_fft_bfly_r2_pipe;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, inv, scale, out_valid, out_ready, out_last, ovf, ovf_clr;
    logic signed [15:0] x0_r, x0_i, x1_r, x1_i, tw_r, tw_i;
    logic signed [15:0] y0_r, y0_i, y1_r, y1_i;

    fft_bfly_r2_pipe #(.N(16), .Q(8), .PAIRS(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x0_r(x0_r), .x0_i(x0_i), .x1_r(x1_r), .x1_i(x1_i), .tw_r(tw_r), .tw_i(tw_i),
        .inv(inv), .scale(scale), .out_valid(out_valid), .out_ready(out_ready),
        .y0_r(y0_r), .y0_i(y0_i), .y1_r(y1_r), .y1_i(y1_i),
        .out_last(out_last), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [15:0] y0r, y0i, y1r, y1i; logic clip; } exp_t;
    typedef struct packed { logic [15:0] y0r, y0i, y1r, y1i; logic last; } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];
    logic last_ovf;
    int   vecs = 0;
    int   errs = 0;

    // Reference butterfly from the arithmetic definition (wide integers).
    function automatic exp_t model(input int x0r, input int x0i, input int x1r, input int x1i,
                                   input int twr, input int twi, input logic iv, input logic sc);
        longint te, tr, ti;
        longint s[4];
        exp_t r;
        te = iv ? ((twi == -32768) ? 32767 : -twi) : twi;
        tr = (longint'(x1r) * twr - longint'(x1i) * te + 128) >>> 8;
        ti = (longint'(x1r) * te + longint'(x1i) * twr + 128) >>> 8;
        s[0] = x0r + tr; s[1] = x0i + ti; s[2] = x0r - tr; s[3] = x0i - ti;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            if (sc) s[k] = (s[k] + 1) >>> 1;
            if (s[k] > 32767)       begin s[k] = 32767;  r.clip = 1'b1; end
            else if (s[k] < -32768) begin s[k] = -32768; r.clip = 1'b1; end
        end
        r.y0r = 16'(s[0]); r.y0i = 16'(s[1]); r.y1r = 16'(s[2]); r.y1i = 16'(s[3]);
        return r;
    endfunction

    // One clock: log handshakes at the falling edge, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        last_ovf = ovf;
        if (rst) begin
            exp_q.delete();
            obs_q.delete();
        end else begin
            if (in_valid && in_ready)
                exp_q.push_back(model(x0_r, x0_i, x1_r, x1_i, tw_r, tw_i, inv, scale));
            if (out_valid && out_ready)
                obs_q.push_back(obs_t'({y0_r, y0_i, y1_r, y1_i, out_last}));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; ovf_clr = 0; out_ready = 1;
        rst = 1; tick(); rst = 0;
    endtask

    task automatic drive_rand();
        x0_r = 16'($urandom); x0_i = 16'($urandom);
        x1_r = 16'($urandom); x1_i = 16'($urandom);
        tw_r = 16'(int'($urandom_range(0, 512)) - 256);
        tw_i = 16'(int'($urandom_range(0, 512)) - 256);
        inv = 1'($urandom); scale = 1'($urandom);
    endtask

    // Single isolated beat; reports the result, its latency and ovf seen with it.
    task automatic run_beat(input int a, input int b, input int c, input int d, input int e,
                            input int f, input logic iv, input logic sc, input logic clr,
                            output obs_t o, output int lat, output logic ov);
        exp_q.delete(); obs_q.delete();
        x0_r = 16'(a); x0_i = 16'(b); x1_r = 16'(c); x1_i = 16'(d); tw_r = 16'(e); tw_i = 16'(f);
        inv = iv; scale = sc; ovf_clr = clr; out_ready = 1; in_valid = 1;
        tick();
        in_valid = 0;
        lat = 0;
        while (obs_q.size() == 0 && lat < 20) begin lat++; tick(); end
        ov = last_ovf;
        ovf_clr = 0;
        if (obs_q.size() != 0) o = obs_q.pop_front(); else begin o = '0; lat = 99; end
        exp_q.delete();
    endtask

    task automatic test_reset();
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vecs++; if ({y0_r, y0_i, y1_r, y1_i} !== 64'd0) begin errs++; $display("FAIL reset_y got %h want 0", {y0_r, y0_i, y1_r, y1_i}); end
        vecs++; if (out_last !== 1'b0) begin errs++; $display("FAIL reset_last got %b want 0", out_last); end
        vecs++; if (ovf !== 1'b0) begin errs++; $display("FAIL reset_ovf got %b want 0", ovf); end
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        obs_t o; int lat; logic ov;
        run_beat(256, 0, 256, 0, 256, 0, 0, 0, 0, o, lat, ov);
        vecs++; if (lat !== 3) begin errs++; $display("FAIL latency got %0d want 3", lat); end
        vecs++; if ({o.y0r, o.y0i, o.y1r, o.y1i} !== {16'sd512, 16'sd0, 16'sd0, 16'sd0}) begin errs++; $display("FAIL basic got %h want 0200000000000000", {o.y0r, o.y0i, o.y1r, o.y1i}); end
        vecs++; if (ov !== 1'b0) begin errs++; $display("FAIL basic_ovf got %b want 0", ov); end
        run_beat(0, 0, 256, 0, 0, -256, 0, 0, 0, o, lat, ov);
        vecs++; if ({o.y0r, o.y0i, o.y1r, o.y1i} !== {16'sd0, -16'sd256, 16'sd0, 16'sd256}) begin errs++; $display("FAIL twiddle got %h want 0000ff000000 0100", {o.y0r, o.y0i, o.y1r, o.y1i}); end
        run_beat(0, 0, 256, 0, 0, -256, 1, 0, 0, o, lat, ov);
        vecs++; if ({o.y0r, o.y0i, o.y1r, o.y1i} !== {16'sd0, 16'sd256, 16'sd0, -16'sd256}) begin errs++; $display("FAIL inverse got %h want 000001000000ff00", {o.y0r, o.y0i, o.y1r, o.y1i}); end
        run_beat(0, 0, 1, 0, 128, 0, 0, 0, 0, o, lat, ov);
        vecs++; if ({o.y0r, o.y0i, o.y1r, o.y1i} !== {16'sd1, 16'sd0, -16'sd1, 16'sd0}) begin errs++; $display("FAIL round_half got %h want 00010000ffff0000", {o.y0r, o.y0i, o.y1r, o.y1i}); end
        run_beat(0, 0, 1, 0, 127, 0, 0, 0, 0, o, lat, ov);
        vecs++; if ({o.y0r, o.y0i, o.y1r, o.y1i} !== 64'd0) begin errs++; $display("FAIL round_below got %h want 0", {o.y0r, o.y0i, o.y1r, o.y1i}); end
        run_beat(0, 0, -1, 0, 128, 0, 0, 0, 0, o, lat, ov);
        vecs++; if ({o.y0r, o.y0i, o.y1r, o.y1i} !== 64'd0) begin errs++; $display("FAIL round_neg_half got %h want 0", {o.y0r, o.y0i, o.y1r, o.y1i}); end
    endtask

    task automatic test_saturation();
        obs_t o; int lat; logic ov;
        run_beat(32767, 0, 32767, 0, 256, 0, 0, 0, 0, o, lat, ov);
        vecs++; if ({o.y0r, o.y0i, o.y1r, o.y1i} !== {16'sd32767, 16'sd0, 16'sd0, 16'sd0}) begin errs++; $display("FAIL sat_y got %h want 7fff000000000000", {o.y0r, o.y0i, o.y1r, o.y1i}); end
        vecs++; if (ov !== 1'b1) begin errs++; $display("FAIL sat_ovf got %b want 1", ov); end
        repeat (3) tick();
        vecs++; if (ovf !== 1'b1) begin errs++; $display("FAIL ovf_sticky got %b want 1", ovf); end
        ovf_clr = 1; tick(); ovf_clr = 0;
        vecs++; if (ovf !== 1'b0) begin errs++; $display("FAIL ovf_clr got %b want 0", ovf); end
        run_beat(32767, 0, 32767, 0, 256, 0, 0, 1, 0, o, lat, ov);
        vecs++; if ({o.y0r, o.y0i, o.y1r, o.y1i} !== {16'sd32767, 16'sd0, 16'sd0, 16'sd0}) begin errs++; $display("FAIL scale_y got %h want 7fff000000000000", {o.y0r, o.y0i, o.y1r, o.y1i}); end
        vecs++; if (ov !== 1'b0) begin errs++; $display("FAIL scale_ovf got %b want 0", ov); end
        // y1 alone clips negative
        run_beat(-32768, 0, 32767, 0, 256, 0, 0, 0, 0, o, lat, ov);
        vecs++; if ({o.y0r, o.y0i, o.y1r, o.y1i} !== {-16'sd1, 16'sd0, -16'sd32768, 16'sd0}) begin errs++; $display("FAIL sat_y1 got %h want ffff000080000000", {o.y0r, o.y0i, o.y1r, o.y1i}); end
        vecs++; if (ov !== 1'b1) begin errs++; $display("FAIL sat_y1_ovf got %b want 1", ov); end
        ovf_clr = 1; tick(); ovf_clr = 0;
        // clear held throughout: the saturating beat still sets ovf
        run_beat(32767, 0, 32767, 0, 256, 0, 0, 0, 1, o, lat, ov);
        vecs++; if (ov !== 1'b1) begin errs++; $display("FAIL set_beats_clr got %b want 1", ov); end
        vecs++; if (ovf !== 1'b0) begin errs++; $display("FAIL clr_after got %b want 0", ovf); end
        // conjugating -32768 pins to +32767 and must not flag
        run_beat(0, 0, 256, 0, 0, -32768, 1, 0, 0, o, lat, ov);
        vecs++; if ({o.y0r, o.y0i, o.y1r, o.y1i} !== {16'sd0, 16'sd32767, 16'sd0, -16'sd32767}) begin errs++; $display("FAIL neg_min got %h want 00007fff00008001", {o.y0r, o.y0i, o.y1r, o.y1i}); end
        vecs++; if (ov !== 1'b0) begin errs++; $display("FAIL neg_min_ovf got %b want 0", ov); end
    endtask

    task automatic test_backpressure();
        int bi; logic hs; logic [64:0] held;
        do_reset();
        bi = 0; held = '0; drive_rand(); x0_i = 16'(0);
        for (int c = 0; c < 24; c++) begin
            out_ready = !(c >= 4 && c <= 7);
            in_valid = (bi < 8);
            #1;
            if (c >= 4 && c <= 7) begin
                vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_in_ready c=%0d got %b want 0", c, in_ready); end
                vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL bp_out_valid c=%0d got %b want 1", c, out_valid); end
                if (c == 4) held = {y0_r, y0_i, y1_r, y1_i, out_last};
                else begin
                    vecs++; if ({y0_r, y0_i, y1_r, y1_i, out_last} !== held) begin errs++; $display("FAIL bp_stable c=%0d got %h want %h", c, {y0_r, y0_i, y1_r, y1_i, out_last}, held); end
                end
            end
            hs = in_valid && in_ready;
            tick();
            if (hs) begin bi++; drive_rand(); x0_i = 16'(bi); end
        end
        vecs++; if (obs_q.size() != 8 || exp_q.size() != 8) begin errs++; $display("FAIL bp_count got %0d/%0d want 8", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < 8 && i < obs_q.size() && i < exp_q.size(); i++) begin
            vecs++;
            if ({obs_q[i].y0r, obs_q[i].y0i, obs_q[i].y1r, obs_q[i].y1i, obs_q[i].last} !==
                {exp_q[i].y0r, exp_q[i].y0i, exp_q[i].y1r, exp_q[i].y1i, 1'b0}) begin
                errs++; $display("FAIL bp_data[%0d] got %h want %h", i, obs_q[i], {exp_q[i].y0r, exp_q[i].y0i, exp_q[i].y1r, exp_q[i].y1i, 1'b0});
            end
        end
    endtask

    task automatic test_random_stream();
        int n; logic anyclip;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive_rand();
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            tick();
        end
        in_valid = 0; out_ready = 1;
        repeat (8) tick();
        vecs++; if (obs_q.size() != exp_q.size()) begin errs++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        anyclip = 0;
        for (int i = 0; i < n; i++) begin
            anyclip |= exp_q[i].clip;
            vecs++;
            if ({obs_q[i].y0r, obs_q[i].y0i, obs_q[i].y1r, obs_q[i].y1i} !== {exp_q[i].y0r, exp_q[i].y0i, exp_q[i].y1r, exp_q[i].y1i}
                || obs_q[i].last !== ((i % 16) == 15)) begin
                errs++; $display("FAIL rand[%0d] got %h last %b want %h last %b", i, {obs_q[i].y0r, obs_q[i].y0i, obs_q[i].y1r, obs_q[i].y1i}, obs_q[i].last, {exp_q[i].y0r, exp_q[i].y0i, exp_q[i].y1r, exp_q[i].y1i}, (i % 16) == 15);
            end
        end
        vecs++; if (ovf !== anyclip) begin errs++; $display("FAIL rand_ovf got %b want %b", ovf, anyclip); end
    endtask

    task automatic test_frame();
        do_reset();
        for (int b = 0; b < 32; b++) begin
            drive_rand();
            if (b == 0) begin
                x0_r = 16'sd32767; x0_i = 0; x1_r = 16'sd32767; x1_i = 0;
                tw_r = 16'sd256; tw_i = 0; inv = 0; scale = 0;
            end
            in_valid = 1;
            tick();
        end
        in_valid = 0;
        repeat (6) tick();
        vecs++; if (obs_q.size() != 32 || exp_q.size() != 32) begin errs++; $display("FAIL frame_count got %0d/%0d want 32", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < 32 && i < obs_q.size() && i < exp_q.size(); i++) begin
            vecs++;
            if ({obs_q[i].y0r, obs_q[i].y0i, obs_q[i].y1r, obs_q[i].y1i} !== {exp_q[i].y0r, exp_q[i].y0i, exp_q[i].y1r, exp_q[i].y1i}
                || obs_q[i].last !== (i == 15 || i == 31)) begin
                errs++; $display("FAIL frame[%0d] got %h last %b want %h last %b", i, {obs_q[i].y0r, obs_q[i].y0i, obs_q[i].y1r, obs_q[i].y1i}, obs_q[i].last, {exp_q[i].y0r, exp_q[i].y0i, exp_q[i].y1r, exp_q[i].y1i}, (i == 15 || i == 31));
            end
        end
        vecs++; if (ovf !== 1'b1) begin errs++; $display("FAIL frame_ovf got %b want 1", ovf); end
        // two beats in flight, then reset
        drive_rand(); in_valid = 1; tick();
        drive_rand(); tick();
        in_valid = 0;
        rst = 1; tick();
        vecs++; if (out_valid !== 1'b0 || ovf !== 1'b0 || out_last !== 1'b0) begin errs++; $display("FAIL midreset got v%b o%b l%b want 000", out_valid, ovf, out_last); end
        rst = 0;
        repeat (6) tick();
        vecs++; if (obs_q.size() != 0) begin errs++; $display("FAIL after_reset_emit got %0d want 0", obs_q.size()); end
        for (int b = 0; b < 16; b++) begin drive_rand(); in_valid = 1; tick(); end
        in_valid = 0;
        repeat (6) tick();
        vecs++; if (obs_q.size() != 16) begin errs++; $display("FAIL frame2_count got %0d want 16", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            vecs++;
            if ({obs_q[i].y0r, obs_q[i].y0i, obs_q[i].y1r, obs_q[i].y1i} !== {exp_q[i].y0r, exp_q[i].y0i, exp_q[i].y1r, exp_q[i].y1i}
                || obs_q[i].last !== (i == 15)) begin
                errs++; $display("FAIL frame2[%0d] got %h last %b want %h last %b", i, {obs_q[i].y0r, obs_q[i].y0i, obs_q[i].y1r, obs_q[i].y1i}, obs_q[i].last, {exp_q[i].y0r, exp_q[i].y0i, exp_q[i].y1r, exp_q[i].y1i}, i == 15);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1; in_valid = 0; out_ready = 1; ovf_clr = 0; inv = 0; scale = 0;
        x0_r = 0; x0_i = 0; x1_r = 0; x1_i = 0; tw_r = 0; tw_i = 0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 0;
        tick();
        test_basic();
        test_saturation();
        test_backpressure();
        test_random_stream();
        test_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/fft_bfly_r2_pipe.md
Name: fft_bfly_r2_pipe

Overview:
Pipelined, streaming radix-2 butterfly engine. It is the time-multiplexed successor to the fully parallel 16-butterfly FFT stage. Each beat accepts one complex pair plus a twiddle and returns y0 = x0 + x1·tw and y1 = x0 − x1·tw. It adds per-beat inverse/scale modes, saturation with a sticky overflow flag, valid/ready backpressure and frame tracking, and sits between the FFT sample buffer and the stage reorder memory.

Parameters:
N, 16, sample/twiddle word width (signed, two's complement)
Q, 8, fractional bits of twiddle (1.0 = 2^Q)
PAIRS, 16, butterflies per frame (one FFT stage); PAIRS ≥ 1

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  input beat valid
in_ready  out  1  engine can accept beat
x0_r, x0_i  in  N  upper input, signed
x1_r, x1_i  in  N  lower input, signed
tw_r, tw_i  in  N  twiddle, signed QN.Q
inv  in  1  1 = conjugate twiddle (IFFT), sampled with beat
scale  in  1  1 = divide outputs by 2, sampled with beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts output
y0_r, y0_i, y1_r, y1_i  out  N  results, signed
out_last  out  1  marks PAIRS-th output of a frame
ovf  out  1  sticky saturation flag
ovf_clr  in  1  clears ovf

Behaviour:
- Reset is synchronous and active-high on clk.
- Reset values: out_valid=0, all y*=0, out_last=0, ovf=0, frame counter=0, all internal stage valids=0. in_ready=1 after reset.
- Pipeline has 3 register stages. Latency is exactly 3 cycles from input handshake to out_valid when no stall occurs.
- Advance condition: adv = !out_valid || out_ready. in_ready = adv (combinational). All stages shift together on adv; bubbles propagate as invalid; nothing is shifted when adv=0. Throughput is 1 beat/cycle.
- Stage 1: register x0, x1, effective twiddle, and scale. tw_i_eff = inv ? −tw_i : tw_i. Negating −2^(N−1) saturates to 2^(N−1)−1 and does not set ovf. Form the 4 products x1_r·tw_r, x1_i·tw_i, x1_r·tw_i_eff, x1_i·tw_r, each 2N bits signed.
- Stage 2: compute t_r = (rr − ii) and t_i = (ri + ir) in 2N+1 bits. Round half-up: t = (p + 2^(Q−1)) >>> Q (arithmetic shift). Keep t in N+2 bits, with no truncation yet.
- Stage 3: compute s0 = x0 + t and s1 = x0 − t at N+3 bits.
  - If scale: s = (s + 1) >>> 1.
  - Then saturate to the N-bit range [−2^(N−1), 2^(N−1)−1].
  - Any component clipping sets ovf. Clipping is tested independently per component, per beat.
- ovf is sticky and is cleared only by rst or ovf_clr. If ovf_clr and a new saturation occur in the same cycle, the new saturation wins (ovf=1).
- Frame counter counts output handshakes (out_valid && out_ready), from 0 to PAIRS−1. out_last = out_valid && (count == PAIRS−1). On that handshake the counter wraps to 0. The counter holds while stalled. For PAIRS=1, out_last=1 on every beat.
- Outputs y*, out_last and out_valid stay stable while out_valid && !out_ready.
- Reset mid-operation discards all in-flight beats. Nothing is emitted after reset until new inputs arrive.

Test Plan:
- N=16, Q=8, scale=0: x0=(256,0), x1=(256,0), tw=(256,0) → 3 cycles later y0=(512,0), y1=(0,0), ovf=0.
- Twiddle and inverse: x0=(0,0), x1=(256,0), tw=(0,−256), inv=0 → y0=(0,−256), y1=(0,256). Same beat with inv=1 → y0=(0,256), y1=(0,−256).
- Rounding: x0=(0,0), x1=(1,0), tw=(128,0) → y0=(1,0), y1=(−1,0). With tw=(127,0) → y0=(0,0).
- Saturation and scale: x0=x1=(32767,0), tw=(256,0):
  - scale=0 → y0=(32767,0) clipped, y1=(0,0), ovf=1 and stays 1.
  - ovf_clr pulse → ovf=0.
  - scale=1 → y0=(32767,0), ovf stays 0.
- Backpressure: stream 8 distinct beats and hold out_ready=0 for cycles 4–7 → in_ready drops within the same cycle as the stall. All 8 outputs arrive in order with no loss or duplicates, and y* stay stable during the stall.
- Frame and reset: PAIRS=16, feed 32 beats back-to-back → out_last high on outputs 16 and 32 only. Then feed 2 beats, assert rst one cycle with both in flight → out_valid=0, ovf=0, counter=0. The next frame's out_last falls on its 16th output.
